// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, address layout and miss-handler states
package dcache_pkg;

  localparam int DC_TAG_W    = 18;
  localparam int DC_INDEX_W  = 8;
  localparam int DC_OFFSET_W = 6;
  localparam int DC_BEAT_W   = 128;

  typedef struct packed {
    logic [DC_TAG_W-1:0]    tag;
    logic [DC_INDEX_W-1:0]  index;
    logic [DC_OFFSET_W-1:0] offset;
  } dcache_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_REQ,
    WB_DATA,
    FILL_REQ,
    FILL_DATA,
    DONE
  } mh_state_t;

endpackage

// File: rtl/dcache_miss_handler_if.sv
// rtl/dcache_miss_handler_if.sv - pipeline, array and memory signals of the miss handler
interface dcache_miss_handler_if
  import dcache_pkg::*;
#(
  parameter int TAG_W   = DC_TAG_W,
  parameter int INDEX_W = DC_INDEX_W,
  parameter int BEAT_W  = DC_BEAT_W
);
  logic               miss_valid;
  logic               miss_ready;
  logic [31:0]        miss_addr;
  logic [1:0]         miss_way;
  logic               miss_dirty;
  logic [TAG_W-1:0]   miss_victim_tag;

  logic               cr_en;
  logic [INDEX_W-1:0] cr_index;
  logic [5:0]         cr_line;
  logic [1:0]         cr_way;
  logic [BEAT_W-1:0]  cr_data;

  logic               cw_en;
  logic [INDEX_W-1:0] cw_index;
  logic [TAG_W-1:0]   cw_tag;
  logic [5:0]         cw_line;
  logic [1:0]         cw_way;
  logic [BEAT_W-1:0]  cw_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [31:0]        mem_req_addr;
  logic               mem_wvalid;
  logic               mem_wready;
  logic [BEAT_W-1:0]  mem_wdata;
  logic               mem_rvalid;
  logic [BEAT_W-1:0]  mem_rdata;

  logic               done;

  modport master (
    input  miss_valid, miss_addr, miss_way, miss_dirty, miss_victim_tag,
    input  cr_data, mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    output miss_ready, cr_en, cr_index, cr_line, cr_way,
    output cw_en, cw_index, cw_tag, cw_line, cw_way, cw_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata, done
  );

  modport slave (
    output miss_valid, miss_addr, miss_way, miss_dirty, miss_victim_tag,
    output cr_data, mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    input  miss_ready, cr_en, cr_index, cr_line, cr_way,
    input  cw_en, cw_index, cw_tag, cw_line, cw_way, cw_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata, done
  );

endinterface

// File: rtl/dcache_line_buffer.sv
// rtl/dcache_line_buffer.sv - four-beat victim line buffer, one write and one read port
module dcache_line_buffer #(
  parameter int BEAT_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [1:0]        raddr,
  output logic [BEAT_W-1:0] rdata
);
  logic [BEAT_W-1:0] mem [4];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_miss_handler.sv
// rtl/dcache_miss_handler.sv - single-miss writeback/refill controller for the 4-way data cache
module dcache_miss_handler
  import dcache_pkg::*;
#(
  parameter int TAG_W   = DC_TAG_W,
  parameter int INDEX_W = DC_INDEX_W,
  parameter int BEAT_W  = DC_BEAT_W
) (
  input logic                   clk,
  input logic                   rst,
  dcache_miss_handler_if.master bus
);
  mh_state_t          state_q, state_d;
  logic [2:0]         rd_cnt_q, rd_cnt_d;
  logic [1:0]         beat_q, beat_d;
  logic [TAG_W-1:0]   tag_q, vtag_q;
  logic [INDEX_W-1:0] index_q;
  logic [1:0]         way_q;
  dcache_addr_t       req;
  logic               accept;
  logic               unused_offset;
  logic               lb_we;
  logic [1:0]         lb_waddr;
  logic [BEAT_W-1:0]  lb_rdata;

  assign req           = bus.miss_addr;
  assign unused_offset = ^req.offset;
  assign accept        = (state_q == IDLE) && bus.miss_valid;
  // Array read data lags cr_en by a cycle, so capture lands one entry behind the count.
  assign lb_waddr      = rd_cnt_q[1:0] - 2'd1;

  dcache_line_buffer #(.BEAT_W(BEAT_W)) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_waddr),
    .wdata (bus.cr_data),
    .raddr (beat_q),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      beat_q   <= '0;
      tag_q    <= '0;
      vtag_q   <= '0;
      index_q  <= '0;
      way_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      beat_q   <= beat_d;
      if (accept) begin
        tag_q   <= req.tag;
        index_q <= req.index;
        vtag_q  <= bus.miss_victim_tag;
        way_q   <= bus.miss_way;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rd_cnt_d          = rd_cnt_q;
    beat_d            = beat_q;
    lb_we             = 1'b0;
    bus.miss_ready    = 1'b0;
    bus.cr_en         = 1'b0;
    bus.cr_index      = '0;
    bus.cr_line       = '0;
    bus.cr_way        = '0;
    bus.cw_en         = 1'b0;
    bus.cw_index      = '0;
    bus.cw_tag        = '0;
    bus.cw_line       = '0;
    bus.cw_way        = '0;
    bus.cw_data       = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_wvalid    = 1'b0;
    bus.mem_wdata     = '0;
    bus.done          = 1'b0;

    case (state_q)
      IDLE: begin
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) begin
          state_d  = bus.miss_dirty ? WB_RD : FILL_REQ;
          rd_cnt_d = '0;
        end
      end
      WB_RD: begin
        bus.cr_en    = ~rd_cnt_q[2];
        bus.cr_index = bus.cr_en ? index_q : '0;
        bus.cr_line  = bus.cr_en ? {rd_cnt_q[1:0], 4'b0} : 6'b0;
        bus.cr_way   = bus.cr_en ? way_q : 2'b0;
        lb_we        = (rd_cnt_q != 3'd0);
        if (rd_cnt_q == 3'd4) begin
          state_d  = WB_REQ;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      WB_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {vtag_q, index_q, 6'b0};
        if (bus.mem_req_ready) begin
          state_d = WB_DATA;
          beat_d  = '0;
        end
      end
      WB_DATA: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = lb_rdata;
        if (bus.mem_wready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {tag_q, index_q, 6'b0};
        if (bus.mem_req_ready) begin
          state_d = FILL_DATA;
          beat_d  = '0;
        end
      end
      FILL_DATA: begin
        // Memory has no backpressure: each fill beat goes straight into the arrays.
        if (bus.mem_rvalid) begin
          bus.cw_en    = 1'b1;
          bus.cw_index = index_q;
          bus.cw_tag   = tag_q;
          bus.cw_line  = {beat_q, 4'b0};
          bus.cw_way   = way_q;
          bus.cw_data  = bus.mem_rdata;
          beat_d       = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        bus.cw_way = way_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb/tb_dcache_miss_handler.sv - self-checking bench for dcache_miss_handler
module tb_dcache_miss_handler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_miss_handler_if bus ();
  dcache_miss_handler dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  way;
    logic        dirty;
    logic [17:0] vtag;
    int          req_stall;
    int          wstall_beat;
    int          wstall;
    logic        pulse;
    logic [31:0] exp_wb;
    logic [31:0] exp_fill;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } req_t;

  typedef struct packed {
    logic [7:0]   index;
    logic [17:0]  tag;
    logic [5:0]   line;
    logic [1:0]   way;
    logic [127:0] data;
  } cw_t;

  req_t         exp_req[$];
  logic [127:0] exp_w[$];
  cw_t          exp_cw[$];
  vec_t         vecs[4];

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  function automatic logic [127:0] arr_data(input logic [7:0] idx, input logic [1:0] way,
                                            input logic [1:0] beat);
    return {4{8'hD0, idx, 6'd0, way, 6'd0, beat}};
  endfunction

  function automatic logic [127:0] fill_data(input int v, input int b);
    logic [7:0] vv;
    logic [7:0] bb;
    vv = 8'(v);
    bb = 8'(b);
    return {4{8'hA0, vv, bb, 8'h5C}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Array read model: data appears the cycle after cr_en.
  logic       pend_en = 1'b0;
  logic [7:0] pend_idx;
  logic [1:0] pend_way;
  logic [1:0] pend_beat;
  always @(negedge clk) begin
    pend_en   = bus.cr_en;
    pend_idx  = bus.cr_index;
    pend_way  = bus.cr_way;
    pend_beat = bus.cr_line[5:4];
  end
  always @(posedge clk) begin
    #1;
    bus.cr_data = pend_en ? arr_data(pend_idx, pend_way, pend_beat) : 128'h0;
  end

  req_t         mon_r;
  cw_t          mon_c;
  logic [127:0] mon_w;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req.size() == 0) unexpected("req_unexpected", bus.mem_req_addr);
        else begin
          mon_r = exp_req.pop_front();
          check("req_we", bus.mem_req_we, mon_r.we);
          check("req_addr", bus.mem_req_addr, mon_r.addr);
        end
      end
      if (bus.mem_wvalid && bus.mem_wready) begin
        if (exp_w.size() == 0) unexpected("wbeat_unexpected", bus.mem_wdata);
        else begin
          mon_w = exp_w.pop_front();
          check("wb_data", bus.mem_wdata, mon_w);
        end
      end
      if (bus.cw_en) begin
        if (exp_cw.size() == 0) unexpected("cw_unexpected", bus.cw_data);
        else begin
          mon_c = exp_cw.pop_front();
          check("cw_index", bus.cw_index, mon_c.index);
          check("cw_tag", bus.cw_tag, mon_c.tag);
          check("cw_line", bus.cw_line, mon_c.line);
          check("cw_way", bus.cw_way, mon_c.way);
          check("cw_data", bus.cw_data, mon_c.data);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!bus.miss_ready && guard < 50) begin
      step();
      guard++;
    end
    check("miss_ready_idle", bus.miss_ready, 1'b1);
  endtask

  task automatic handle_req(input int stall, input logic pulse, input logic [31:0] exp_addr,
                            input logic exp_we);
    int guard;
    guard = 0;
    while (!bus.mem_req_valid && guard < 40) begin
      step();
      guard++;
    end
    check("req_seen", bus.mem_req_valid, 1'b1);
    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      if (pulse) begin
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h5555_5540;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = '1;
        bus.mem_wready = 1'b1;
        check("busy_miss_ready", bus.miss_ready, 1'b0);
      end
      check("req_hold_valid", bus.mem_req_valid, 1'b1);
      check("req_hold_addr", bus.mem_req_addr, exp_addr);
      check("req_hold_we", bus.mem_req_we, exp_we);
      step();
    end
    bus.miss_valid    = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_wready    = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic drive_miss(input int id, input logic [31:0] addr, input logic [1:0] way,
                            input logic dirty, input logic [17:0] vtag,
                            input logic [31:0] wb_addr, input logic [31:0] fill_addr,
                            input int n_fill);
    logic [7:0]  idx;
    logic [17:0] tag;
    logic [1:0]  bb;
    idx = addr[13:6];
    tag = addr[31:14];
    bus.miss_valid      = 1'b1;
    bus.miss_addr       = addr;
    bus.miss_way        = way;
    bus.miss_dirty      = dirty;
    bus.miss_victim_tag = vtag;
    if (dirty) begin
      exp_req.push_back('{we: 1'b1, addr: wb_addr});
      for (int b = 0; b < 4; b++) begin
        bb = 2'(b);
        exp_w.push_back(arr_data(idx, way, bb));
      end
    end
    exp_req.push_back('{we: 1'b0, addr: fill_addr});
    for (int b = 0; b < n_fill; b++) begin
      bb = 2'(b);
      exp_cw.push_back('{index: idx, tag: tag, line: {bb, 4'b0}, way: way, data: fill_data(id, b)});
    end
    step();
    bus.miss_valid      = 1'b0;
    bus.miss_addr       = 32'hFFFF_FFFF;
    bus.miss_way        = ~way;
    bus.miss_dirty      = 1'b0;
    bus.miss_victim_tag = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          lat;
    int          nb;
    int          left;
    int          guard;
    logic [31:0] cr_mask;
    logic [7:0]  idx;
    logic [1:0]  bb;
    v   = vecs[i];
    idx = v.addr[13:6];
    wait_idle();
    drive_miss(i, v.addr, v.way, v.dirty, v.vtag, v.exp_wb, v.exp_fill, 4);
    lat     = 1;
    cr_mask = '0;
    while (!bus.mem_req_valid && lat < 20) begin
      if (bus.cr_en) cr_mask[lat] = 1'b1;
      step();
      lat++;
    end
    if (bus.cr_en) cr_mask[lat] = 1'b1;
    check($sformatf("v%0d_req_latency", i), lat, v.exp_lat);
    check($sformatf("v%0d_cr_en_cycles", i), cr_mask, v.dirty ? 32'h1E : 32'h0);
    if (v.dirty) begin
      handle_req(v.req_stall, 1'b0, v.exp_wb, 1'b1);
      nb    = 0;
      left  = v.wstall;
      guard = 0;
      while (nb < 4 && guard < 40) begin
        if (nb == v.wstall_beat && left > 0) begin
          bus.mem_wready = 1'b0;
          bb = 2'(nb);
          check("wdata_hold", bus.mem_wdata, arr_data(idx, v.way, bb));
          check("wvalid_hold", bus.mem_wvalid, 1'b1);
          left--;
        end else begin
          bus.mem_wready = 1'b1;
          nb++;
        end
        step();
        guard++;
      end
      bus.mem_wready = 1'b0;
    end
    handle_req(v.req_stall, v.pulse, v.exp_fill, 1'b0);
    for (int b = 0; b < 4; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = fill_data(i, b);
      step();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    check($sformatf("v%0d_done", i), bus.done, 1'b1);
    check($sformatf("v%0d_done_way", i), bus.cw_way, v.way);
    check($sformatf("v%0d_done_ready", i), bus.miss_ready, 1'b0);
    step();
    check($sformatf("v%0d_done_pulse", i), bus.done, 1'b0);
    check($sformatf("v%0d_ready_after", i), bus.miss_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    vecs[0] = '{addr: 32'h0001_2340, way: 2'd2, dirty: 1'b0, vtag: 18'h0, req_stall: 0,
                wstall_beat: 0, wstall: 0, pulse: 1'b0, exp_wb: 32'h0,
                exp_fill: 32'h0001_2340, exp_lat: 1};
    vecs[1] = '{addr: 32'h0001_2340, way: 2'd1, dirty: 1'b1, vtag: 18'h3FFFF, req_stall: 0,
                wstall_beat: 1, wstall: 3, pulse: 1'b0, exp_wb: 32'hFFFF_E340,
                exp_fill: 32'h0001_2340, exp_lat: 6};
    vecs[2] = '{addr: 32'hABCD_E7C5, way: 2'd3, dirty: 1'b0, vtag: 18'h0, req_stall: 5,
                wstall_beat: 0, wstall: 0, pulse: 1'b1, exp_wb: 32'h0,
                exp_fill: 32'hABCD_E7C0, exp_lat: 1};
    vecs[3] = '{addr: 32'h0000_0040, way: 2'd0, dirty: 1'b1, vtag: 18'h00001, req_stall: 2,
                wstall_beat: 3, wstall: 1, pulse: 1'b0, exp_wb: 32'h0000_4040,
                exp_fill: 32'h0000_0040, exp_lat: 6};

    bus.miss_valid      = 1'b0;
    bus.miss_addr       = '0;
    bus.miss_way        = '0;
    bus.miss_dirty      = 1'b0;
    bus.miss_victim_tag = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_wready      = 1'b0;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_miss_ready", bus.miss_ready, 1'b1);
    check("rst_strobes", {bus.cr_en, bus.cw_en, bus.mem_req_valid, bus.mem_wvalid, bus.done}, 5'b0);
    check("rst_addr_outs", {bus.cr_index, bus.cr_line, bus.cr_way, bus.cw_index, bus.cw_tag,
                            bus.cw_line, bus.cw_way, bus.mem_req_addr, bus.mem_req_we}, 83'h0);
    check("rst_cw_data", bus.cw_data, 128'h0);
    check("rst_wdata", bus.mem_wdata, 128'h0);

    for (int i = 0; i < 4; i++) run_vec(i);
    check("done_pulses", done_cnt, 4);

    // Reset in the middle of a fill: two beats land, then the miss is dropped.
    dc = done_cnt;
    wait_idle();
    drive_miss(9, 32'h0000_1FC0, 2'd1, 1'b0, 18'h0, 32'h0, 32'h0000_1FC0, 2);
    handle_req(0, 1'b0, 32'h0000_1FC0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = fill_data(9, b);
      step();
    end
    bus.mem_rvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = fill_data(9, 2);
    check("midrst_miss_ready", bus.miss_ready, 1'b1);
    check("midrst_cw_en", bus.cw_en, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_req_valid", bus.mem_req_valid, 1'b0);
    step();
    bus.mem_rdata = fill_data(9, 3);
    check("midrst_cw_en_later", bus.cw_en, 1'b0);
    check("midrst_ready_later", bus.miss_ready, 1'b1);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    check("midrst_no_done", done_cnt, dc);
    check("sb_drained", exp_req.size() + exp_w.size() + exp_cw.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_miss_handler.md
# dcache_miss_handler

Miss/refill controller for the 4-way data cache: accepts one miss from the load/store pipeline, drains the dirty victim line out of the cache arrays to memory, fetches the new line from memory, and writes it into the arrays one 128-bit beat at a time. Sits between the data-cache arrays and the memory interface, and is the initiator that drives the arrays' read and write ports during a miss. Handles one outstanding miss; the pipeline stalls until `done`.

## Interface
- `TAG_W`, 18: tag width.
- `INDEX_W`, 8: set index width.
- `BEAT_W`, 128: beat width; 4 beats per 64-byte line.
- `clk`, in, 1: clock; everything is on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `miss_valid`, in, 1: miss request.
- `miss_ready`, out, 1: handler is idle and accepts a miss.
- `miss_addr`, in, 32: missing address as {tag[31:14], index[13:6], offset[5:0]}.
- `miss_way`, in, 2: victim way chosen by the tag check.
- `miss_dirty`, in, 1: victim is valid and dirty.
- `miss_victim_tag`, in, 18: victim tag.
- `cr_en`, out, 1: array read strobe, used as the no-tagcheck read.
- `cr_index`, out, 8: array read index.
- `cr_line`, out, 6: array read line; bits [5:4] select the beat.
- `cr_way`, out, 2: array read way.
- `cr_data`, in, 128: array read data, valid the cycle after `cr_en`.
- `cw_en`, out, 1: array write strobe.
- `cw_index`, out, 8: array write index.
- `cw_tag`, out, 18: array write tag.
- `cw_line`, out, 6: array write line.
- `cw_way`, out, 2: array write way.
- `cw_data`, out, 128: array write data.
- `mem_req_valid`, out, 1: memory request valid.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_we`, out, 1: 1 for writeback, 0 for fill.
- `mem_req_addr`, out, 32: line-aligned address; bits [5:0] are 0.
- `mem_wvalid`, out, 1: writeback beat valid.
- `mem_wready`, in, 1: writeback beat accepted.
- `mem_wdata`, out, 128: writeback beat data.
- `mem_rvalid`, in, 1: fill beat valid. There is no backpressure; the handler always accepts.
- `mem_rdata`, in, 128: fill beat data.
- `done`, out, 1: one-cycle pulse when the line is installed. Carries the way on `cw_way`.

## Operation
- States: IDLE, WB_RD, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, DONE.
- In IDLE, `miss_ready`=1. On `miss_valid&miss_ready`, latch the address, way, dirty bit and victim tag.
  - Go to WB_RD if `miss_dirty`.
  - Go to FILL_REQ otherwise.
- WB_RD: a 3-bit counter runs 0..4.
  - At counts 0..3, assert `cr_en` with `cr_line`={count[1:0],4'b0}, `cr_index`=latched index, `cr_way`=victim way.
  - At counts 1..4, capture `cr_data` into line buffer entry count-1.
  - After count 4, go to WB_REQ.
- WB_REQ: `mem_req_valid`=1, `mem_req_we`=1, `mem_req_addr`={victim_tag,index,6'b0}. Hold until `mem_req_ready`, then go to WB_DATA.
- WB_DATA: present beats 0..3 in order on `mem_wdata` with `mem_wvalid`=1. Advance on `mem_wready`. After beat 3 is accepted, go to FILL_REQ.
- FILL_REQ: `mem_req_valid`=1, `mem_req_we`=0, `mem_req_addr`={miss tag,index,6'b0}. Go to FILL_DATA on `mem_req_ready`.
- FILL_DATA: each `mem_rvalid` produces `cw_en`=1 combinationally in the same cycle, with:
  - `cw_data`=`mem_rdata`;
  - `cw_line`={beat,4'b0};
  - `cw_tag`=miss tag;
  - `cw_way`=latched way.
  - The beat counter increments. After beat 3, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. The pipeline replays the access and updates metadata by its normal tag check.
- Beat counters are 2 bits and wrap 3→0. They are cleared on entry to WB_DATA and FILL_DATA.
- `mem_rvalid` outside FILL_DATA, and `mem_wready` outside WB_DATA, are ignored.
- `miss_valid` while not IDLE is ignored (`miss_ready`=0).

## Timing
- Reset: state=IDLE and counters=0. In the cycle after the reset edge, `miss_ready`=1 and every other output is 0; data/address outputs are 0.
- Reset mid-miss: abandon the miss immediately with no `done`. Beats already written stay in the arrays, but that way is never validated by the handler.
- Dirty miss accepted at cycle T:
  - `cr_en` is high in T+1..T+4.
  - The last capture happens at T+5.
  - `mem_req_valid` is first high at T+6.
- Clean miss accepted at T: `mem_req_valid` is first high at T+1.
- Fill: the last `mem_rvalid` in cycle F gives `done` at F+1 and `miss_ready` at F+2.
- `mem_req_valid` and `mem_wvalid` stay asserted, with stable address/data, until accepted.

## Structure
- `dcache_pkg` holds:
  - the TAG/INDEX/BEAT widths;
  - the `dcache_addr_t` packed struct {tag, index, offset};
  - the `mh_state_t` enum.
- Sub-module `dcache_line_buffer`: a 4×128 register file with one write port and one read port, indexed by beat.

## Test plan
- Clean miss, addr 0x0001_2340, way 2; memory returns beats A0..A3 with 0 wait → `mem_req_addr`=0x0001_2340 with we=0; four `cw_en` on `cw_line` 0x00/0x10/0x20/0x30, way 2; `done` one cycle after the last beat.
- Dirty miss, victim tag 0x3FFFF, index 0x8D, array beats D0..D3 → `cr_en` at T+1..T+4; writeback at 0xFFFF_E340 carries D0..D3 in order; then a fill request.
- `mem_wready` low for 3 cycles on beat 1 → `mem_wdata` holds D1 stable; no beat is skipped or duplicated.
- `mem_req_ready` low for 5 cycles, and `miss_valid` pulsed while busy → request held; second miss not accepted.
- `rst` asserted during FILL_DATA after 2 beats → next cycle IDLE with `miss_ready`=1, no `done`, no further `cw_en` even if `mem_rvalid` continues.
